// File: rtl/seven_segment_scanner_if.sv
// Bundle of value/strobe inputs and display pin outputs for seven_segment_scanner.
// master = datapath/bench side, slave = scanner side.
interface seven_segment_scanner_if #(
  parameter int DIGIT_COUNT = 4
);
  logic [4*DIGIT_COUNT-1:0] value;
  logic [DIGIT_COUNT-1:0]   pointEnable;
  logic [DIGIT_COUNT-1:0]   digitEnable;
  logic                     load;
  logic [7:0]               segmentEnableN;
  logic [DIGIT_COUNT-1:0]   digitSelectN;
  logic                     frameStart;

  modport master (
    output value, pointEnable, digitEnable, load,
    input  segmentEnableN, digitSelectN, frameStart
  );

  modport slave (
    input  value, pointEnable, digitEnable, load,
    output segmentEnableN, digitSelectN, frameStart
  );
endinterface

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed common-anode seven-segment driver with tear-free frame updates.
// Optional macro LEADING_ZERO_SUPPRESS_EN blanks leading zero digits (digit 0 always shown).
module seven_segment_scanner #(
  parameter int DIGIT_COUNT    = 4,
  parameter int REFRESH_DIVIDE = 50000,
  parameter int BLANK_CYCLES   = 16
) (
  input  logic                   clock,
  input  logic                   resetN,
  seven_segment_scanner_if.slave bus
);
  localparam int TICK_W = (REFRESH_DIVIDE > 1) ? $clog2(REFRESH_DIVIDE) : 1;
  localparam int IDX_W  = (DIGIT_COUNT > 1) ? $clog2(DIGIT_COUNT) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(REFRESH_DIVIDE - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGIT_COUNT - 1);

  logic [TICK_W-1:0]        tick_q, tick_d;
  logic [IDX_W-1:0]         index_q, index_d;
  logic [4*DIGIT_COUNT-1:0] pend_value_q, pend_value_d, act_value_q, act_value_d;
  logic [DIGIT_COUNT-1:0]   pend_point_q, pend_point_d, act_point_q, act_point_d;
  logic [DIGIT_COUNT-1:0]   pend_enable_q, pend_enable_d, act_enable_q, act_enable_d;
  logic [7:0]               seg_q, seg_d;
  logic [DIGIT_COUNT-1:0]   sel_q, sel_d;
  logic                     frame_q, frame_d;

  logic                     in_blank;
  logic [DIGIT_COUNT-1:0]   digit_blank;
  logic [7:0]               digit_seg [DIGIT_COUNT];

  // Active-high segment pattern, bit order {ctr, ltop, lbot, bot, rbot, rtop, top}
  function automatic logic [6:0] glyph(input logic [3:0] nibble);
    logic [6:0] g;
    case (nibble)
      4'h0: g = 7'h3F;  4'h1: g = 7'h06;  4'h2: g = 7'h5B;  4'h3: g = 7'h4F;
      4'h4: g = 7'h66;  4'h5: g = 7'h6D;  4'h6: g = 7'h7D;  4'h7: g = 7'h07;
      4'h8: g = 7'h7F;  4'h9: g = 7'h6F;  4'hA: g = 7'h77;  4'hB: g = 7'h7C;
      4'hC: g = 7'h39;  4'hD: g = 7'h5E;  4'hE: g = 7'h79;  default: g = 7'h71;
    endcase
    return g;
  endfunction

  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign in_blank = 1'b0;
    end else begin : g_blank
      assign in_blank = (tick_q < TICK_W'(BLANK_CYCLES));
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < DIGIT_COUNT; gi++) begin : g_digit
      assign digit_seg[gi] = ~{act_point_q[gi], glyph(act_value_q[gi*4 +: 4])};
    end
  endgenerate

`ifdef LEADING_ZERO_SUPPRESS_EN
  // zero_above[k]: digit k and every higher digit are a bare zero
  logic [DIGIT_COUNT:1] zero_above;
  assign zero_above[DIGIT_COUNT] = 1'b1;
  generate
    for (gi = 0; gi < DIGIT_COUNT; gi++) begin : g_suppress
      if (gi == 0) begin : g_lsd
        assign digit_blank[gi] = 1'b0;
      end else begin : g_upper
        assign zero_above[gi] = (act_value_q[gi*4 +: 4] == 4'h0) && !act_point_q[gi]
                                && zero_above[gi+1];
        assign digit_blank[gi] = zero_above[gi];
      end
    end
  endgenerate
`else
  assign digit_blank = '0;
`endif

  always_comb begin
    tick_d        = tick_q;
    index_d       = index_q;
    pend_value_d  = pend_value_q;
    pend_point_d  = pend_point_q;
    pend_enable_d = pend_enable_q;
    act_value_d   = act_value_q;
    act_point_d   = act_point_q;
    act_enable_d  = act_enable_q;
    seg_d         = 8'hFF;
    sel_d         = '1;
    frame_d       = (tick_q == '0) && (index_q == '0);

    if (tick_q == TICK_LAST) begin
      tick_d  = '0;
      index_d = (index_q == IDX_LAST) ? '0 : index_q + 1'b1;
    end else begin
      tick_d = tick_q + 1'b1;
    end

    if (bus.load) begin
      pend_value_d  = bus.value;
      pend_point_d  = bus.pointEnable;
      pend_enable_d = bus.digitEnable;
    end

    // Copy on the wrap edge; taking the _d values gives same-cycle load bypass
    if ((tick_q == TICK_LAST) && (index_q == IDX_LAST)) begin
      act_value_d  = pend_value_d;
      act_point_d  = pend_point_d;
      act_enable_d = pend_enable_d;
    end

    if (!in_blank && act_enable_q[index_q]) begin
      sel_d[index_q] = 1'b0;
      seg_d          = digit_blank[index_q] ? 8'hFF : digit_seg[index_q];
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      tick_q        <= '0;
      index_q       <= '0;
      pend_value_q  <= '0;
      pend_point_q  <= '0;
      pend_enable_q <= '0;
      act_value_q   <= '0;
      act_point_q   <= '0;
      act_enable_q  <= '0;
      seg_q         <= 8'hFF;
      sel_q         <= '1;
      frame_q       <= 1'b0;
    end else begin
      tick_q        <= tick_d;
      index_q       <= index_d;
      pend_value_q  <= pend_value_d;
      pend_point_q  <= pend_point_d;
      pend_enable_q <= pend_enable_d;
      act_value_q   <= act_value_d;
      act_point_q   <= act_point_d;
      act_enable_q  <= act_enable_d;
      seg_q         <= seg_d;
      sel_q         <= sel_d;
      frame_q       <= frame_d;
    end
  end

  assign bus.segmentEnableN = seg_q;
  assign bus.digitSelectN   = sel_q;
  assign bus.frameStart     = frame_q;
endmodule

// File: tb/tb_seven_segment_scanner.sv
// Randomized bench for seven_segment_scanner against a cycle-count based display model.
// Define LEADING_ZERO_SUPPRESS_EN for both bench and RTL to cover the suppression build.
module tb_seven_segment_scanner;
  localparam int DC    = 4;
  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = DC * RD;

  // Active-low pin patterns for hex digits, point off
  localparam logic [7:0] PINS [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic clock  = 1'b0;
  logic resetN = 1'b0;
  always #5 clock = ~clock;

  seven_segment_scanner_if #(.DIGIT_COUNT(DC)) bus();

  seven_segment_scanner #(
    .DIGIT_COUNT   (DC),
    .REFRESH_DIVIDE(RD),
    .BLANK_CYCLES  (BC)
  ) dut (
    .clock (clock),
    .resetN(resetN),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Model: cycles since reset release plus pending/active shadow of the loaded data
  int          t;
  logic [15:0] m_pval, m_aval;
  logic [3:0]  m_ppt, m_apt, m_pen, m_aen;
  logic [7:0]  exp_seg;
  logic [3:0]  exp_sel;
  logic        exp_fs;
  int          cyc;
  int          last_fs;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", tag, got, exp, t, $time);
    end
  endtask

  task automatic model_reset();
    t       = 0;
    m_pval  = '0; m_aval = '0;
    m_ppt   = '0; m_apt  = '0;
    m_pen   = '0; m_aen  = '0;
    exp_seg = 8'hFF;
    exp_sel = 4'hF;
    exp_fs  = 1'b0;
    last_fs = -1;
  endtask

  // Output the DUT should show after the edge that ends model cycle t, then advance
  task automatic model_edge();
    int  slot_tick, digit;
    bit  supp;
    slot_tick = t % RD;
    digit     = (t / RD) % DC;
    exp_fs    = (t % FRAME) == 0;
    exp_seg   = 8'hFF;
    exp_sel   = 4'hF;
    if (slot_tick >= BC && m_aen[digit]) begin
      exp_sel = 4'hF ^ (4'b0001 << digit);
      exp_seg = PINS[m_aval[4*digit +: 4]];
      if (m_apt[digit]) exp_seg[7] = 1'b0;
`ifdef LEADING_ZERO_SUPPRESS_EN
      supp = (digit != 0);
      for (int j = digit; j < DC; j++)
        if (m_aval[4*j +: 4] != 4'h0 || m_apt[j]) supp = 1'b0;
      if (supp) exp_seg = 8'hFF;
`else
      supp = 1'b0;
`endif
    end
    if (bus.load) begin
      m_pval = bus.value;
      m_ppt  = bus.pointEnable;
      m_pen  = bus.digitEnable;
    end
    if ((t % FRAME) == FRAME - 1) begin
      m_aval = m_pval;
      m_apt  = m_ppt;
      m_aen  = m_pen;
    end
    t++;
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_eq("seg", 32'(bus.segmentEnableN), 32'(exp_seg));
    check_eq("sel", 32'(bus.digitSelectN), 32'(exp_sel));
    check_eq("frame", 32'(bus.frameStart), 32'(exp_fs));
    if (bus.frameStart) begin
      if (last_fs >= 0) check_eq("frame_period", 32'(cyc - last_fs), 32'(FRAME));
      last_fs = cyc;
    end
    cyc++;
  endtask

  task automatic drive(input logic ld, input logic [15:0] v, input logic [3:0] p, input logic [3:0] e);
    bus.load        = ld;
    bus.value       = v;
    bus.pointEnable = p;
    bus.digitEnable = e;
  endtask

  task automatic drive_random();
    logic [15:0] v;
    logic [3:0]  p, e;
    logic        ld;
    for (int k = 0; k < DC; k++)
      v[4*k +: 4] = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom);
    p  = ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0;
    e  = ($urandom_range(9) < 7) ? 4'hF : 4'($urandom);
    if ((t % FRAME) == FRAME - 1) ld = ($urandom_range(1) == 0);
    else                          ld = ($urandom_range(5) == 0);
    drive(ld, v, p, e);
  endtask

  // Called at a falling edge: drop reset mid-cycle, load under reset, then release
  task automatic async_reset();
    #2 resetN = 1'b0;
    #1;
    check_eq("rst_seg", 32'(bus.segmentEnableN), 32'h0000_00FF);
    check_eq("rst_sel", 32'(bus.digitSelectN), 32'h0000_000F);
    check_eq("rst_frame", 32'(bus.frameStart), 32'h0);
    drive(1'b1, 16'hFFFF, 4'hF, 4'hF);
    @(negedge clock);
    check_eq("rst_hold_seg", 32'(bus.segmentEnableN), 32'h0000_00FF);
    drive(1'b0, 16'h0, 4'h0, 4'h0);
    resetN = 1'b1;
    model_reset();
  endtask

  initial begin
    cyc = 0;
    model_reset();
    drive(1'b0, 16'h0, 4'h0, 4'h0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_eq("init_seg", 32'(bus.segmentEnableN), 32'h0000_00FF);
    check_eq("init_sel", 32'(bus.digitSelectN), 32'h0000_000F);
    check_eq("init_frame", 32'(bus.frameStart), 32'h0);
    resetN = 1'b1;

    // Load 1234 with point on digit 1, then scan two full frames
    drive(1'b1, 16'h1234, 4'b0010, 4'hF);
    step();
    drive(1'b0, 16'h0, 4'h0, 4'h0);
    repeat (2 * FRAME + 3) step();

    // Mid-frame load must not tear the current frame
    drive(1'b1, 16'hFFFF, 4'h0, 4'hF);
    step();
    drive(1'b0, 16'h0, 4'h0, 4'h0);
    repeat (2 * FRAME) step();

    // Leading-zero pattern with and without the top point
    while ((t % FRAME) != FRAME - 1) step();
    drive(1'b1, 16'h0050, 4'h0, 4'hF);
    step();
    drive(1'b0, 16'h0, 4'h0, 4'h0);
    repeat (FRAME) step();
    drive(1'b1, 16'h0050, 4'b1000, 4'b1011);
    step();
    drive(1'b0, 16'h0, 4'h0, 4'h0);
    repeat (2 * FRAME) step();

    for (int n = 0; n < 3000; n++) begin
      if (n == 1500 + 0) begin
        repeat ($urandom_range(RD - 1)) step();
        async_reset();
      end
      drive_random();
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
